// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM block.
// Holds the counting-mode and direction encodings plus the register map
// helpers, so every file agrees on where period and mode live relative to
// the channel duty registers.
package pwm_pkg;

    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTRE = 1'b1;

    localparam logic DIR_UP      = 1'b0;
    localparam logic DIR_DOWN    = 1'b1;

    // Period register sits just above the last channel duty register.
    function automatic int addr_period(input int ch);
        return ch;
    endfunction

    // Mode register sits just above the period register.
    function automatic int addr_mode(input int ch);
        return ch + 32'sd1;
    endfunction

endpackage

// File: rtl/pwm_multi_if.sv
// Control/status bundle of the multi-channel PWM block.
// master: drives en and the register write port, observes outputs.
// slave : the PWM block itself.
//   en          timebase enable
//   wr_en       register write strobe
//   wr_addr     0..CH-1 duty, CH period, CH+1 mode
//   wr_data     write data
//   pwm         per-channel outputs (inversion applied)
//   period_tick one-cycle pulse at the first count of each period
//   cnt_out     current timebase count
interface pwm_multi_if #(
    parameter int WIDTH = 8,
    parameter int CH    = 4,
    parameter int AW    = $clog2(CH + 32'sd2)
);
    logic             en;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [CH-1:0]    pwm;
    logic             period_tick;
    logic [WIDTH-1:0] cnt_out;

    modport master (
        output en, wr_en, wr_addr, wr_data,
        input  pwm, period_tick, cnt_out
    );

    modport slave (
        input  en, wr_en, wr_addr, wr_data,
        output pwm, period_tick, cnt_out
    );
endinterface

// File: rtl/pwm_timebase.sv
// Shared timebase for all PWM channels.
// Owns the counter, count direction, active/shadow period and mode, the
// boundary detector and the registered period tick.
//   clk, rst    clock and synchronous active-high reset
//   en_i        count enable (count and direction hold while low)
//   wr_per_i    write strobe for the period shadow register
//   wr_mode_i   write strobe for the mode shadow register
//   wr_data_i   write data
//   cnt_o       registered count
//   boundary_o  high in the last cycle of a period (combinational)
//   tick_o      registered pulse on the first count of a new period
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] DEF_PERIOD = {WIDTH{1'b1}}
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             wr_per_i,
    input  logic             wr_mode_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             boundary_o,
    output logic             tick_o
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] per_act_q, per_act_d;
    logic [WIDTH-1:0] per_sh_q, per_sh_d;
    logic             dir_q, dir_d;
    logic             mode_act_q, mode_act_d;
    logic             mode_sh_q, mode_sh_d;
    logic             tick_q;
    logic [WIDTH-1:0] per_eff_s;
    logic [WIDTH-1:0] cnt_inc_s;
    logic             boundary_s;

    // Effective period and boundary detection for the current mode.
    always_comb begin
        per_eff_s  = per_act_q;
        boundary_s = 1'b0;
        cnt_inc_s  = cnt_q + ONE;
        // A zero period would make the centre sequence degenerate; run it as 1.
        if ((mode_act_q == MODE_CENTRE) && (per_act_q == '0)) begin
            per_eff_s = ONE;
        end else begin
            per_eff_s = per_act_q;
        end
        if (!en_i) begin
            boundary_s = 1'b0;
        end else if (mode_act_q == MODE_EDGE) begin
            boundary_s = (cnt_q == per_act_q);
        end else begin
            boundary_s = (dir_q == DIR_DOWN) && (cnt_q == ONE);
        end
    end

    // Next-state of counter, direction and period/mode registers.
    always_comb begin
        per_sh_d   = wr_per_i  ? wr_data_i    : per_sh_q;
        mode_sh_d  = wr_mode_i ? wr_data_i[0] : mode_sh_q;
        per_act_d  = per_act_q;
        mode_act_d = mode_act_q;
        cnt_d      = cnt_q;
        dir_d      = dir_q;
        if (boundary_s) begin
            // Shadow values, including a write landing this very cycle,
            // become active and every new period restarts from zero upward.
            per_act_d  = per_sh_d;
            mode_act_d = mode_sh_d;
            cnt_d      = '0;
            dir_d      = DIR_UP;
        end else if (!en_i) begin
            cnt_d = cnt_q;
            dir_d = dir_q;
        end else if (mode_act_q == MODE_EDGE) begin
            cnt_d = cnt_inc_s;
            dir_d = DIR_UP;
        end else if (dir_q == DIR_UP) begin
            // dir describes the next step, so it is already DOWN while the
            // count sits at the peak; this also keeps P=1 at two cycles.
            cnt_d = cnt_inc_s;
            dir_d = (cnt_inc_s == per_eff_s) ? DIR_DOWN : DIR_UP;
        end else begin
            cnt_d = cnt_q - ONE;
            dir_d = DIR_DOWN;
        end
    end

    // Timebase state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            dir_q      <= DIR_UP;
            per_act_q  <= DEF_PERIOD;
            per_sh_q   <= DEF_PERIOD;
            mode_act_q <= MODE_EDGE;
            mode_sh_q  <= MODE_EDGE;
            tick_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            dir_q      <= dir_d;
            per_act_q  <= per_act_d;
            per_sh_q   <= per_sh_d;
            mode_act_q <= mode_act_d;
            mode_sh_q  <= mode_sh_d;
            tick_q     <= boundary_s;
        end
    end

    assign cnt_o      = cnt_q;
    assign boundary_o = boundary_s;
    assign tick_o     = tick_q;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator with a shared timebase.
// Each channel has a shadow and an active duty register; the active copy is
// refreshed only at a period boundary so outputs never glitch mid-period.
//   clk, rst  clock and synchronous active-high reset
//   bus       pwm_multi_if slave: en, register write port, pwm,
//             period_tick and cnt_out
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter int               CH         = 4,
    parameter logic [WIDTH-1:0] DEF_PERIOD = {WIDTH{1'b1}},
    parameter logic [CH-1:0]    INV_MASK   = {CH{1'b0}},
    parameter int               AW         = $clog2(CH + 32'sd2)
)(
    input  logic       clk,
    input  logic       rst,
    pwm_multi_if.slave bus
);

    localparam logic [AW-1:0] ADDR_PER = AW'(addr_period(CH));
    localparam logic [AW-1:0] ADDR_MOD = AW'(addr_mode(CH));

    logic             wr_per_s;
    logic             wr_mode_s;
    logic             boundary_s;
    logic             tick_s;
    logic [WIDTH-1:0] cnt_s;
    logic [CH-1:0]    pwm_s;

    // Decode period and mode writes; addresses above the mode slot match nothing.
    always_comb begin
        wr_per_s  = bus.wr_en && (bus.wr_addr == ADDR_PER);
        wr_mode_s = bus.wr_en && (bus.wr_addr == ADDR_MOD);
    end

    pwm_timebase #(
        .WIDTH      (WIDTH),
        .DEF_PERIOD (DEF_PERIOD)
    ) u_timebase (
        .clk        (clk),
        .rst        (rst),
        .en_i       (bus.en),
        .wr_per_i   (wr_per_s),
        .wr_mode_i  (wr_mode_s),
        .wr_data_i  (bus.wr_data),
        .cnt_o      (cnt_s),
        .boundary_o (boundary_s),
        .tick_o     (tick_s)
    );

    for (genvar g = 0; g < CH; g++) begin : g_ch
        logic [WIDTH-1:0] duty_sh_q, duty_sh_d;
        logic [WIDTH-1:0] duty_act_q, duty_act_d;
        logic             pwm_q, pwm_d;
        logic             wr_hit_s;
        logic             raw_s;

        // Duty shadowing and compare; the compare sees the pre-boundary duty
        // in the last cycle of a period, so 100% duty never drops at wrap.
        always_comb begin
            wr_hit_s   = bus.wr_en && (bus.wr_addr == AW'(g));
            duty_sh_d  = wr_hit_s ? bus.wr_data : duty_sh_q;
            duty_act_d = boundary_s ? duty_sh_d : duty_act_q;
            raw_s      = (cnt_s < duty_act_q);
            pwm_d      = bus.en ? (raw_s ^ INV_MASK[g]) : INV_MASK[g];
        end

        // Per-channel duty registers and output flop.
        always_ff @(posedge clk) begin
            if (rst) begin
                duty_sh_q  <= '0;
                duty_act_q <= '0;
                pwm_q      <= INV_MASK[g];
            end else begin
                duty_sh_q  <= duty_sh_d;
                duty_act_q <= duty_act_d;
                pwm_q      <= pwm_d;
            end
        end

        assign pwm_s[g] = pwm_q;
    end

    assign bus.pwm         = pwm_s;
    assign bus.period_tick = tick_s;
    assign bus.cnt_out     = cnt_s;

endmodule

// File: tb/tb_pwm_multi.sv
module tb_pwm_multi;

    localparam int WIDTH = 4;
    localparam int CH    = 2;
    localparam int AW    = $clog2(CH + 2);
    localparam logic [CH-1:0] INV_A = 2'b00;
    localparam logic [CH-1:0] INV_B = 2'b10;
    localparam int NV = 7;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pwm_multi_if #(.WIDTH(WIDTH), .CH(CH), .AW(AW)) bus_a ();
    pwm_multi_if #(.WIDTH(WIDTH), .CH(CH), .AW(AW)) bus_b ();

    assign bus_b.en      = bus_a.en;
    assign bus_b.wr_en   = bus_a.wr_en;
    assign bus_b.wr_addr = bus_a.wr_addr;
    assign bus_b.wr_data = bus_a.wr_data;

    pwm_multi #(.WIDTH(WIDTH), .CH(CH), .DEF_PERIOD(4'hF), .INV_MASK(INV_A), .AW(AW))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    pwm_multi #(.WIDTH(WIDTH), .CH(CH), .DEF_PERIOD(4'hF), .INV_MASK(INV_B), .AW(AW))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    int n_chk = 0;
    int n_pass = 0;

    // Reference model: position within the period, period length and the
    // count at each position are derived directly from the counting rules.
    int          m_pos;
    int          m_per_a, m_per_s, m_mode_a, m_mode_s;
    int          m_duty_a [CH];
    int          m_duty_s [CH];
    logic [CH-1:0] m_pwm_a, m_pwm_b;
    logic        m_tick;
    logic [WIDTH-1:0] m_cnt;

    typedef struct {
        int per; int mode; int d0; int d1;
        int len; int act0; int act1;
    } vec_t;
    vec_t tbl [NV];

    function automatic int plen(input int mode, input int p);
        if (mode == 0) return p + 1;
        return 2 * ((p == 0) ? 1 : p);
    endfunction

    function automatic int cnt_at(input int mode, input int p, input int pos);
        int pe;
        pe = (p == 0) ? 1 : p;
        if (mode == 0) return pos;
        return (pos <= pe) ? pos : (2 * pe - pos);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_step();
        int c;
        int len;
        int wd;
        int wa;
        logic bnd;
        if (rst) begin
            m_pos = 0;
            m_per_a = 15; m_per_s = 15;
            m_mode_a = 0; m_mode_s = 0;
            for (int i = 0; i < CH; i++) begin
                m_duty_a[i] = 0;
                m_duty_s[i] = 0;
            end
            m_pwm_a = INV_A;
            m_pwm_b = INV_B;
            m_tick = 1'b0;
        end else begin
            c   = cnt_at(m_mode_a, m_per_a, m_pos);
            len = plen(m_mode_a, m_per_a);
            bnd = bus_a.en && (m_pos == len - 1);
            for (int i = 0; i < CH; i++) begin
                m_pwm_a[i] = bus_a.en ? ((c < m_duty_a[i]) ^ INV_A[i]) : INV_A[i];
                m_pwm_b[i] = bus_a.en ? ((c < m_duty_a[i]) ^ INV_B[i]) : INV_B[i];
            end
            wd = int'(bus_a.wr_data);
            wa = int'(bus_a.wr_addr);
            if (bus_a.wr_en) begin
                if (wa < CH) m_duty_s[wa] = wd;
                else if (wa == CH) m_per_s = wd;
                else if (wa == CH + 1) m_mode_s = wd % 2;
            end
            if (bnd) begin
                m_per_a = m_per_s;
                m_mode_a = m_mode_s;
                for (int i = 0; i < CH; i++) m_duty_a[i] = m_duty_s[i];
                m_pos = 0;
            end else if (bus_a.en) begin
                m_pos++;
            end
            m_tick = bnd;
        end
        m_cnt = 4'(cnt_at(m_mode_a, m_per_a, m_pos));
    endtask

    // One clock: advance the model with the inputs seen at the edge, then
    // compare both instances shortly after the edge.
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("pwm_a", 32'(bus_a.pwm), 32'(m_pwm_a));
        chk("pwm_b", 32'(bus_b.pwm), 32'(m_pwm_b));
        chk("tick", 32'({bus_a.period_tick, bus_b.period_tick}), 32'({m_tick, m_tick}));
        chk("cnt", 32'({bus_a.cnt_out, bus_b.cnt_out}), 32'({m_cnt, m_cnt}));
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        bus_a.wr_en = 1'b1;
        bus_a.wr_addr = a;
        bus_a.wr_data = d;
        cyc();
        bus_a.wr_en = 1'b0;
    endtask

    task automatic wait_tick();
        int g;
        g = 0;
        while (!bus_a.period_tick && g < 80) begin
            cyc();
            g++;
        end
        chk("wait_tick", 32'(bus_a.period_tick), 32'd1);
    endtask

    task automatic wait_cnt(input logic [WIDTH-1:0] v);
        int g;
        g = 0;
        while (bus_a.cnt_out != v && g < 80) begin
            cyc();
            g++;
        end
        chk("wait_cnt", 32'(bus_a.cnt_out), 32'(v));
    endtask

    // Run until the next tick, counting cycles and active (non-inverted)
    // output cycles; optionally write duty0 after wr_at samples.
    task automatic measure(input int wr_at, input logic [WIDTH-1:0] wr_val,
                           output int n, output int a0a, output int a1a,
                           output int a0b, output int a1b);
        n = 0; a0a = 0; a1a = 0; a0b = 0; a1b = 0;
        while (n < 80) begin
            if (n == wr_at) begin
                bus_a.wr_en = 1'b1;
                bus_a.wr_addr = 2'd0;
                bus_a.wr_data = wr_val;
            end
            cyc();
            bus_a.wr_en = 1'b0;
            n++;
            a0a += int'(bus_a.pwm[0] ^ INV_A[0]);
            a1a += int'(bus_a.pwm[1] ^ INV_A[1]);
            a0b += int'(bus_b.pwm[0] ^ INV_B[0]);
            a1b += int'(bus_b.pwm[1] ^ INV_B[1]);
            if (bus_a.period_tick) break;
        end
    endtask

    initial begin
        int n, a0a, a1a, a0b, a1b, g;

        //            per mode d0 d1  len act0 act1
        tbl[0] = '{  9,  0,   3,  0,  10,  3,   0 };
        tbl[1] = '{  9,  0,   3, 12,  10,  3,  10 };
        tbl[2] = '{  8,  1,   3,  8,  16,  5,  15 };
        tbl[3] = '{  8,  1,   0,  9,  16,  0,  16 };
        tbl[4] = '{ 15,  0,  15,  1,  16, 15,   1 };
        tbl[5] = '{  0,  1,   1,  2,   2,  1,   2 };
        tbl[6] = '{  0,  0,   0,  1,   1,  0,   1 };

        rst = 1'b1;
        bus_a.en = 1'b0;
        bus_a.wr_en = 1'b0;
        bus_a.wr_addr = '0;
        bus_a.wr_data = '0;

        // Reset defaults.
        repeat (3) cyc();
        chk("rst_pwm_a", 32'(bus_a.pwm), 32'h0);
        chk("rst_pwm_b", 32'(bus_b.pwm), 32'h2);
        chk("rst_tick", 32'(bus_a.period_tick), 32'h0);
        chk("rst_cnt", 32'(bus_a.cnt_out), 32'h0);

        // First tick 16 cycles after release with the default period.
        rst = 1'b0;
        bus_a.en = 1'b1;
        n = 0;
        while (n < 40) begin
            cyc();
            n++;
            if (bus_a.period_tick) break;
        end
        chk("first_tick", 32'(n), 32'd16);

        // Table of steady-state period configurations.
        for (int v = 0; v < NV; v++) begin
            wr(2'd0, 4'(tbl[v].d0));
            wr(2'd1, 4'(tbl[v].d1));
            wr(2'd2, 4'(tbl[v].per));
            wr(2'd3, 4'(tbl[v].mode));
            wait_tick();
            measure(-1, 4'd0, n, a0a, a1a, a0b, a1b);
            chk($sformatf("v%0d_len", v), 32'(n), 32'(tbl[v].len));
            chk($sformatf("v%0d_a_act0", v), 32'(a0a), 32'(tbl[v].act0));
            chk($sformatf("v%0d_a_act1", v), 32'(a1a), 32'(tbl[v].act1));
            chk($sformatf("v%0d_b_act0", v), 32'(a0b), 32'(tbl[v].act0));
            chk($sformatf("v%0d_b_act1", v), 32'(a1b), 32'(tbl[v].act1));
        end

        // Shadowing: mid-period write waits for the boundary.
        wr(2'd2, 4'd9);
        wr(2'd3, 4'd0);
        wr(2'd0, 4'd3);
        wr(2'd1, 4'd0);
        wait_tick();
        measure(4, 4'd7, n, a0a, a1a, a0b, a1b);
        chk("shadow_cur_len", 32'(n), 32'd10);
        chk("shadow_cur_d0", 32'(a0a), 32'd3);
        measure(-1, 4'd0, n, a0a, a1a, a0b, a1b);
        chk("shadow_next_d0", 32'(a0a), 32'd7);

        // Write in the boundary cycle applies to the new period at once.
        wait_cnt(4'd9);
        wr(2'd0, 4'd2);
        chk("bnd_wr_tick", 32'(bus_a.period_tick), 32'd1);
        measure(-1, 4'd0, n, a0a, a1a, a0b, a1b);
        chk("bnd_wr_d0", 32'(a0a), 32'd2);
        chk("bnd_wr_len", 32'(n), 32'd10);

        // Enable low holds the count and forces the idle level.
        wait_cnt(4'd5);
        bus_a.en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("hold_cnt", 32'(bus_a.cnt_out), 32'd5);
            chk("hold_pwm_a", 32'(bus_a.pwm), 32'h0);
            chk("hold_pwm_b", 32'(bus_b.pwm), 32'h2);
        end
        bus_a.en = 1'b1;
        cyc();
        chk("resume_cnt", 32'(bus_a.cnt_out), 32'd6);

        // Reset mid-period.
        wait_cnt(4'd7);
        rst = 1'b1;
        cyc();
        chk("midrst_cnt", 32'(bus_a.cnt_out), 32'd0);
        chk("midrst_pwm_a", 32'(bus_a.pwm), 32'h0);
        chk("midrst_pwm_b", 32'(bus_b.pwm), 32'h2);
        chk("midrst_tick", 32'(bus_a.period_tick), 32'd0);
        rst = 1'b0;

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 199) == 0);
            bus_a.en = ($urandom_range(0, 9) != 0);
            bus_a.wr_en = ($urandom_range(0, 3) == 0);
            bus_a.wr_addr = 2'($urandom_range(0, 3));
            g = $urandom_range(0, 15);
            bus_a.wr_data = 4'(g);
            cyc();
        end
        rst = 1'b0;
        bus_a.wr_en = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
